// File: rtl/regfile_sched_pkg.sv
// Shared types and helpers for the register-file port scheduler.
package regfile_sched_pkg;

  typedef enum logic [1:0] {
    REQ_READ = 2'd0,
    REQ_WB0  = 2'd1,
    REQ_WB1  = 2'd2
  } req_e;

  localparam int unsigned NUM_WB    = 2;
  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned NUM_REGS  = 2 ** ADDR_BITS;

  function automatic logic [NUM_REGS-1:0] onehot_addr(input logic [ADDR_BITS-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_port_sched_if.sv
// Bundle of read-request, writeback and register-file signals around the scheduler.
interface regfile_port_sched_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
);
  logic                    rd_valid;
  logic                    rd_ready;
  logic [REGBITS-1:0]      rd_a1;
  logic [REGBITS-1:0]      rd_a2;
  logic                    rd_done;
  logic [WIDTH-1:0]        rd_d1;
  logic [WIDTH-1:0]        rd_d2;
  logic [1:0]              wb_valid;
  logic [1:0]              wb_ready;
  logic [2*REGBITS-1:0]    wb_addr;
  logic [2*WIDTH-1:0]      wb_data;
  logic [REGBITS-1:0]      rf_ra1;
  logic [REGBITS-1:0]      rf_ra2;
  logic [WIDTH-1:0]        rf_wd;
  logic                    rf_regwrite;
  logic [WIDTH-1:0]        rf_rd1;
  logic [WIDTH-1:0]        rf_rd2;
  logic [2**REGBITS-1:0]   pending;

  modport master (
    output rd_valid, rd_a1, rd_a2, wb_valid, wb_addr, wb_data, rf_rd1, rf_rd2,
    input  rd_ready, rd_done, rd_d1, rd_d2, wb_ready, rf_ra1, rf_ra2, rf_wd, rf_regwrite, pending
  );

  modport slave (
    input  rd_valid, rd_a1, rd_a2, wb_valid, wb_addr, wb_data, rf_rd1, rf_rd2,
    output rd_ready, rd_done, rd_d1, rd_d2, wb_ready, rf_ra1, rf_ra2, rf_wd, rf_regwrite, pending
  );
endinterface

// File: rtl/regfile_port_sched_rr_arbiter3.sv
// Three-way round-robin arbiter; pointer names the highest-priority requester next cycle.
module rr_arbiter3
  import regfile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] eligible,
  output logic [2:0] grant
);

  req_e ptr_q, ptr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= REQ_READ;
    else          ptr_q <= ptr_d;
  end

  always_comb begin
    grant = 3'b000;
    unique case (ptr_q)
      REQ_READ: begin
        if      (eligible[0]) grant = 3'b001;
        else if (eligible[1]) grant = 3'b010;
        else if (eligible[2]) grant = 3'b100;
      end
      REQ_WB0: begin
        if      (eligible[1]) grant = 3'b010;
        else if (eligible[2]) grant = 3'b100;
        else if (eligible[0]) grant = 3'b001;
      end
      REQ_WB1: begin
        if      (eligible[2]) grant = 3'b100;
        else if (eligible[0]) grant = 3'b001;
        else if (eligible[1]) grant = 3'b010;
      end
      default: grant = 3'b000;
    endcase

    ptr_d = ptr_q;
    if (grant[0]) ptr_d = REQ_WB0;
    if (grant[1]) ptr_d = REQ_WB1;
    if (grant[2]) ptr_d = REQ_READ;
  end

endmodule

// File: rtl/regfile_port_sched.sv
// Shares a 2R/1W register file (write address aliased onto ra2) between one reader
// and two writeback slots, blocking reads of registers with buffered writes.
module regfile_port_sched
  import regfile_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = ADDR_BITS
) (
  input logic                  clk,
  input logic                  reset_n,
  regfile_port_sched_if.slave  bus
);

  localparam int unsigned NREGS = 2 ** REGBITS;

  logic [NUM_WB-1:0]              occ_q;
  logic [NUM_WB-1:0][REGBITS-1:0] addr_q;
  logic [NUM_WB-1:0][WIDTH-1:0]   data_q;
  logic                           rd_done_q;
  logic [WIDTH-1:0]               rd_d1_q, rd_d2_q;

  logic [NREGS-1:0] pend;
  logic [2:0]       eligible, grant;

  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (occ_q[i]) pend |= onehot_addr(addr_q[i]);
    end
  end

  assign eligible = {occ_q[1], occ_q[0],
                     bus.rd_valid && !pend[bus.rd_a1] && !pend[bus.rd_a2]};

  rr_arbiter3 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .eligible (eligible),
    .grant    (grant)
  );

  logic [REGBITS-1:0] ra1, ra2;
  logic [WIDTH-1:0]   wd;
  logic               regwrite, rd_ready;

  // Write grants drive the slot address onto ra2, which doubles as the write address.
  always_comb begin
    ra1      = '0;
    ra2      = '0;
    wd       = '0;
    regwrite = 1'b0;
    rd_ready = 1'b0;
    if (grant[0]) begin
      ra1      = bus.rd_a1;
      ra2      = bus.rd_a2;
      rd_ready = 1'b1;
    end else if (grant[1]) begin
      ra2      = addr_q[0];
      wd       = data_q[0];
      regwrite = 1'b1;
    end else if (grant[2]) begin
      ra2      = addr_q[1];
      wd       = data_q[1];
      regwrite = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_done_q <= 1'b0;
      rd_d1_q   <= '0;
      rd_d2_q   <= '0;
    end else begin
      rd_done_q <= grant[0];
      if (grant[0]) begin
        rd_d1_q <= bus.rf_rd1;
        rd_d2_q <= bus.rf_rd2;
      end
      for (int i = 0; i < NUM_WB; i++) begin
        if (grant[i+1]) begin
          occ_q[i] <= 1'b0;
        end else if (bus.wb_valid[i] && !occ_q[i] &&
                     bus.wb_addr[i*REGBITS +: REGBITS] != '0) begin
          // r0 writes are acknowledged but never buffered
          occ_q[i]  <= 1'b1;
          addr_q[i] <= bus.wb_addr[i*REGBITS +: REGBITS];
          data_q[i] <= bus.wb_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.wb_ready    = ~occ_q;
  assign bus.pending     = pend;
  assign bus.rd_ready    = rd_ready;
  assign bus.rd_done     = rd_done_q;
  assign bus.rd_d1       = rd_d1_q;
  assign bus.rd_d2       = rd_d2_q;
  assign bus.rf_ra1      = ra1;
  assign bus.rf_ra2      = ra2;
  assign bus.rf_wd       = wd;
  assign bus.rf_regwrite = regwrite;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Scoreboard bench: a transaction-level scheduler model predicts grants and read data;
// a monitor pops expected read data whenever rd_done is seen.
module tb_regfile_port_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_sched_if #(.WIDTH(16), .REGBITS(4)) bus ();

  regfile_port_sched #(.WIDTH(16), .REGBITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register file: combinational reads, write on rising edge, r0 hardwired to zero.
  logic [15:0] mem [16] = '{default: 16'h0};
  assign bus.rf_rd1 = mem[bus.rf_ra1];
  assign bus.rf_rd2 = mem[bus.rf_ra2];
  always @(posedge clk) if (bus.rf_regwrite && bus.rf_ra2 != 4'd0) mem[bus.rf_ra2] <= bus.rf_wd;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  bit          occ [2];
  logic [3:0]  saddr [2];
  logic [15:0] sdata [2];
  logic [15:0] regs [16] = '{default: 16'h0};
  int          ptr = 0;  // 0 = READ, 1 = WB0, 2 = WB1
  bit          m_done = 1'b0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    occ[0] = 1'b0; occ[1] = 1'b0;
    ptr = 0;
    m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic cycle(input bit rv, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [1:0] wv, input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic [15:0] wd0, input logic [15:0] wd1);
    int win;
    int idx;
    logic [15:0] pend;
    bit el [3];
    bit rdy [2];
    logic [3:0] wa [2];
    logic [15:0] wdat [2];
    @(negedge clk);
    bus.rd_valid = rv;
    bus.rd_a1    = a1;
    bus.rd_a2    = a2;
    bus.wb_valid = wv;
    bus.wb_addr  = {wa1, wa0};
    bus.wb_data  = {wd1, wd0};
    #1;
    pend = '0;
    for (int i = 0; i < 2; i++) if (occ[i]) pend[saddr[i]] = 1'b1;
    el[0] = rv && !pend[a1] && !pend[a2];
    el[1] = occ[0];
    el[2] = occ[1];
    win = -1;
    for (int k = 0; k < 3; k++) begin
      idx = (ptr + k) % 3;
      if (win < 0 && el[idx]) win = idx;
    end
    check("pending", bus.pending, pend);
    check("wb_ready", bus.wb_ready, {!occ[1], !occ[0]});
    check("rd_ready", bus.rd_ready, win == 0);
    check("rf_regwrite", bus.rf_regwrite, win > 0);
    check("rd_done", bus.rd_done, m_done);
    if (win == 0) begin
      check("rf_ra1_read", bus.rf_ra1, a1);
      check("rf_ra2_read", bus.rf_ra2, a2);
      exp_q.push_back({regs[a1], regs[a2]});
    end else if (win > 0) begin
      check("rf_ra2_write", bus.rf_ra2, saddr[win-1]);
      check("rf_wd", bus.rf_wd, sdata[win-1]);
    end else begin
      check("rf_ra1_idle", bus.rf_ra1, 0);
      check("rf_ra2_idle", bus.rf_ra2, 0);
    end
    // Advance the model to the state after the coming edge
    rdy[0] = !occ[0];
    rdy[1] = !occ[1];
    wa[0] = wa0; wa[1] = wa1; wdat[0] = wd0; wdat[1] = wd1;
    m_done = (win == 0);
    if (win > 0) begin
      regs[saddr[win-1]] = sdata[win-1];
      occ[win-1] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (wv[i] && rdy[i] && wa[i] != 4'd0) begin
        occ[i] = 1'b1;
        saddr[i] = wa[i];
        sdata[i] = wdat[i];
      end
    end
    if (win >= 0) ptr = (win + 1) % 3;
    @(posedge clk);
  endtask

  // Monitor: compare registered read data against the scoreboard on each rd_done.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.rd_done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_done_unexpected: got rd_done=1, expected no read outstanding");
        end else begin
          e = exp_q.pop_front();
          check("rd_d1", bus.rd_d1, e[31:16]);
          check("rd_d2", bus.rd_d2, e[15:0]);
        end
      end
    end
  end

  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_a1    = '0;
    bus.rd_a2    = '0;
    bus.wb_valid = '0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_ready", bus.wb_ready, 2'b11);
    check("rst_pending", bus.pending, 0);
    check("rst_regwrite", bus.rf_regwrite, 0);
    check("rst_rd_done", bus.rd_done, 0);
    check("rst_rd_d1", bus.rd_d1, 0);
    check("rst_rd_d2", bus.rd_d2, 0);
    check("rst_rf_ra2", bus.rf_ra2, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: plain read, write-then-read hazard, r0 write, same address, contention
    cycle(1, 4'd3, 4'd5, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cycle(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cycle(1, 4'd3, 4'd0, 2'b01, 4'd3, 4'd0, 16'h1234, 16'h0);
    repeat (3) cycle(1, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cycle(0, 4'd0, 4'd0, 2'b10, 4'd0, 4'd0, 16'h0, 16'hFFFF);
    cycle(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cycle(0, 4'd0, 4'd0, 2'b11, 4'd7, 4'd7, 16'hAAAA, 16'h5555);
    repeat (4) cycle(1, 4'd7, 4'd7, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    for (int n = 0; n < 9; n++)
      cycle(1, 4'd1, 4'd2, 2'b11, 4'd4, 4'd5, 16'(n), 16'(n + 100));

    // Randomized traffic over a narrow register range to provoke hazards
    for (int n = 0; n < 600; n++)
      cycle(1'($urandom % 2), 4'($urandom % 8), 4'($urandom % 8), 2'($urandom % 4),
            4'($urandom % 8), 4'($urandom % 8), 16'($urandom), 16'($urandom));

    repeat (6) cycle(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);

    // Async reset while both slots hold data
    cycle(0, 4'd0, 4'd0, 2'b11, 4'd9, 4'd10, 16'hBEEF, 16'hCAFE);
    #2;
    check("pre_rst_regwrite", bus.rf_regwrite, 1);
    bus.wb_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    check("async_rst_regwrite", bus.rf_regwrite, 0);
    check("async_rst_pending", bus.pending, 0);
    check("async_rst_wb_ready", bus.wb_ready, 2'b11);
    @(posedge clk);
    #1;
    check("async_rst_r9", mem[9], regs[9]);
    check("async_rst_r10", mem[10], regs[10]);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 50; n++)
      cycle(1'($urandom % 2), 4'($urandom % 12), 4'($urandom % 12), 2'($urandom % 4),
            4'($urandom % 12), 4'($urandom % 12), 16'($urandom), 16'($urandom));
    repeat (6) cycle(0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    check("reads_outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Sequences the 16x16 register file, which has two combinational read ports (ra1/ra2 → rd1/rd2) and one synchronous write port.
- The write address of that register file is shared with read port 2 (ra2), so a write cycle and a port-2 read cannot coexist.
- This block owns ra1/ra2/wd/regwrite and shares the register file between one core read requester and two writeback requesters (ALU, load).
- It tracks pending writes to block RAW hazards and returns registered read data one cycle after grant.

Parameters:
- WIDTH, 16, data width.
- REGBITS, 4, register address width (2**REGBITS registers; r0 reads 0, writes to r0 discarded).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_valid  in  1  core read request
- rd_ready  out  1  read granted this cycle
- rd_a1  in  REGBITS  source register 1
- rd_a2  in  REGBITS  source register 2
- rd_done  out  1  read data valid (one cycle after grant)
- rd_d1  out  WIDTH  registered data for rd_a1
- rd_d2  out  WIDTH  registered data for rd_a2
- wb_valid  in  2  writeback request, [0]=ALU, [1]=load
- wb_ready  out  2  writeback slot empty / can accept
- wb_addr  in  2*REGBITS  packed destination addresses
- wb_data  in  2*WIDTH  packed write data
- rf_ra1  out  REGBITS  to register file ra1
- rf_ra2  out  REGBITS  to register file ra2 (read addr or write addr)
- rf_wd  out  WIDTH  to register file wd
- rf_regwrite  out  1  to register file regwrite
- rf_rd1  in  WIDTH  from register file rd1
- rf_rd2  in  WIDTH  from register file rd2
- pending  out  2**REGBITS  bitmask of registers with a buffered, unwritten value

Behaviour:
- Reset (async, reset_n=0):
  - both wb slots empty, so wb_ready=2'b11
  - rd_ready=0, rd_done=0, rd_d1=rd_d2=0
  - rf_regwrite=0, rf_ra1=rf_ra2=0, rf_wd=0
  - pending=0, round-robin pointer=READ
- Write slots: one entry per requester.
  - Accept when wb_valid[i]&&wb_ready[i]; wb_ready[i] = slot i empty (registered).
  - An accepted write with addr 0 is acknowledged but never stored; the slot stays empty.
  - pending is the OR of the decoded addresses of the occupied slots.
- Grant, once per cycle, among {READ, WB0, WB1}, round-robin.
  - Eligible READ: rd_valid && !pending[rd_a1] && !pending[rd_a2].
  - Eligible WBi: slot i occupied.
  - The pointer advances to the requester after the winner. It holds when nothing is granted.
- Outputs to the register file (combinational from state + grant):
  - Read grant: rf_ra1=rd_a1, rf_ra2=rd_a2, rf_regwrite=0, rd_ready=1. Next edge: rd_d1<=rf_rd1, rd_d2<=rf_rd2, rd_done<=1.
  - WBi grant: rf_ra2=slot addr, rf_wd=slot data, rf_regwrite=1. The slot empties at that edge and pending clears; new data is visible to reads from the next cycle.
  - Idle: rf_regwrite=0, addresses held at 0.
- rd_done is a 1-cycle pulse; rd_d1/rd_d2 hold their value until the next read grant.
- Both slots hold the same address: both are pending. They drain in round-robin order; the later grant's value is final. Software ordering is the requesters' responsibility.
- Slot accept and grant of the same slot in the same cycle is impossible, because wb_ready is derived from registered occupancy.
- Read blocked by pending: rd_ready stays 0 until the matching slot drains, with no starvation. Round-robin guarantees a drain within 2 cycles.
- reset_n asserted mid-operation: buffered writes are discarded, not flushed, and rf_regwrite drops immediately.

Decomposition:
- Package regfile_sched_pkg:
  - requester enum {REQ_READ, REQ_WB0, REQ_WB1}
  - NUM_WB=2
  - function onehot_addr(addr) → pending mask
- One sub-module is natural: rr_arbiter3, 3-input round-robin with registered pointer, eligible in, one-hot grant out.
- Slots and output muxing stay in the top.

Test Plan:
- Reset: hold reset_n=0 → wb_ready=11, pending=0, rf_regwrite=0, rd_done=0. Release, rd_valid=1 with a1=3, a2=5 → grant in cycle 0, rd_done=1 in cycle 1 with rf values.
- Write then read: WB0 writes r3=0x1234 while rd_valid (a1=3) is asserted the same cycle → read stalls while pending[3]=1. rf_regwrite=1 with rf_ra2=3, rf_wd=0x1234, then read granted; rd_d1=0x1234.
- r0 write: WB1 addr=0, data=0xFFFF → accepted, wb_ready[1] stays 1, no rf_regwrite, pending=0.
- Contention: rd_valid plus both slots full with r1, r2, all continuous → grants rotate READ, WB0, WB1, READ…, each exactly once per 3 cycles.
- Same-address: WB0 r7=0xAAAA and WB1 r7=0x5555 accepted together → two write cycles; pending[7] clears only after both. Final r7 equals the second-granted value.
- Async reset mid-operation: both slots full, pull reset_n low between edges → rf_regwrite=0 immediately, pending=0; no write occurs at the next edge.
